// File: rtl/instruction_loader.sv
// Serial byte loader: packs received bytes MSB-first into 32-bit words and
// writes them to instruction memory. Optional checksum stage: LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inStart,
  input  logic [7:0]  inRxData,
  input  logic        inRxDone,
  output logic [31:0] outInstruction,
  output logic        outWrInstruction,
  output logic [31:0] outWrAddress,
  output logic        outStopPC,
  output logic        outLoadDone,
  output logic        outOverflow,
  output logic        outChecksumErr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd3;
`endif
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [31:0] LAST = 32'(DEPTH - 1);

  logic [2:0]  state;
  logic [1:0]  byteCnt;
  logic [31:0] word;
  logic [31:0] addr;
  logic        ovf;
  logic        isHalt;

  assign isHalt = (word == HALT_WORD);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xorAcc;
  logic       chkErr;

  // Running XOR of every accepted byte; cleared whenever a load (re)starts
  always_ff @(posedge clk) begin
    if (rst || inStart) begin
      xorAcc <= 8'd0;
    end else if (inRxDone && (state == LOAD ||
                 (state == WRITE && !isHalt && addr != LAST))) begin
      xorAcc <= xorAcc ^ inRxData;
    end
  end

  // Sticky mismatch flag, evaluated on the byte that follows the halt word
  always_ff @(posedge clk) begin
    if (rst || inStart) begin
      chkErr <= 1'b0;
    end else if (inRxDone && (state == CHECK ||
                 (state == WRITE && isHalt))) begin
      chkErr <= (inRxData != xorAcc);
    end
  end

  assign outChecksumErr = chkErr;
`else
  assign outChecksumErr = 1'b0;
`endif

  // Main loader FSM: byte assembly, write sequencing, halt and overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      byteCnt <= 2'd0;
      word    <= 32'd0;
      addr    <= 32'd0;
      ovf     <= 1'b0;
    end else if (inStart) begin
      state   <= LOAD;
      byteCnt <= 2'd0;
      word    <= 32'd0;
      addr    <= 32'd0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (inRxDone) begin
            word    <= {word[23:0], inRxData};
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          addr    <= addr + 32'd1;
          byteCnt <= 2'd0;
          if (isHalt) begin
`ifdef LOADER_CHECKSUM_EN
            state <= inRxDone ? DONE : CHECK;
`else
            state <= DONE;
`endif
          end else if (addr == LAST) begin
            ovf   <= 1'b1;
            state <= DONE;
          end else begin
            state <= LOAD;
            if (inRxDone) begin
              word    <= {word[23:0], inRxData};
              byteCnt <= 2'd1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (inRxDone) state <= DONE;
        end
`endif
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign outInstruction   = word;
  assign outWrAddress     = addr;
  // Reset gates the strobe immediately so a pending write never escapes
  assign outWrInstruction = (state == WRITE) && !rst;
`ifdef LOADER_CHECKSUM_EN
  assign outStopPC = (state == LOAD) || (state == WRITE) ||
                     (state == CHECK);
`else
  assign outStopPC = (state == LOAD) || (state == WRITE);
`endif
  assign outLoadDone = (state == DONE);
  assign outOverflow = ovf;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader (DEPTH=4): table of words plus
// hand sequences for restart, collisions, back-to-back bytes and reset.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        inStart;
  logic [7:0]  inRxData;
  logic        inRxDone;
  logic [31:0] outInstruction;
  logic        outWrInstruction;
  logic [31:0] outWrAddress;
  logic        outStopPC;
  logic        outLoadDone;
  logic        outOverflow;
  logic        outChecksumErr;

  int nChecks = 0;
  int nFails  = 0;
  int nStrobes = 0;

  instruction_loader #(.DEPTH(4), .HALT_WORD(32'hFFFFFFFF)) dut (
    .clk(clk), .rst(rst), .inStart(inStart),
    .inRxData(inRxData), .inRxDone(inRxDone),
    .outInstruction(outInstruction),
    .outWrInstruction(outWrInstruction),
    .outWrAddress(outWrAddress), .outStopPC(outStopPC),
    .outLoadDone(outLoadDone), .outOverflow(outOverflow),
    .outChecksumErr(outChecksumErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (outWrInstruction) nStrobes++;

  typedef struct {
    bit          start;
    logic [31:0] word;
    bit          expStrobe;
    logic [31:0] expAddr;
    bit          expDone;
    bit          expOvf;
    bit          expStop;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    inRxData = b;
    inRxDone = 1'b1;
    @(negedge clk);
    inRxDone = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
  endtask

  task automatic pulseStart();
    inStart = 1'b1;
    @(negedge clk);
    inStart = 1'b0;
  endtask

  initial begin
    int base;
    vecs[0] = '{1, 32'h20010005, 1, 0, 0, 0, 1};
    vecs[1] = '{0, 32'h12345678, 1, 1, 0, 0, 1};
    vecs[2] = '{0, 32'hFFFFFFFF, 1, 2, 1, 0, 0};
    vecs[3] = '{0, 32'hAABBCCDD, 0, 0, 1, 0, 0};
    vecs[4] = '{1, 32'h00000001, 1, 0, 0, 0, 1};
    vecs[5] = '{0, 32'h00000002, 1, 1, 0, 0, 1};
    vecs[6] = '{0, 32'h00000003, 1, 2, 0, 0, 1};
    vecs[7] = '{0, 32'h00000004, 1, 3, 1, 1, 0};
    vecs[8] = '{0, 32'h00000005, 0, 0, 1, 1, 0};
    vecs[9] = '{1, 32'hFFFFFFFF, 1, 0, 1, 0, 0};

    rst = 1'b1; inStart = 1'b0; inRxData = 8'h00; inRxDone = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_instr", outInstruction, 32'h0);
    check("rst_addr", outWrAddress, 32'h0);
    check("rst_flags", {outWrInstruction, outStopPC, outLoadDone,
                        outOverflow, outChecksumErr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    sendByte(8'h55);
    check("idle_ignores_rx", {outStopPC, outLoadDone}, 32'h0);
    check("idle_no_strobe", nStrobes, 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].start) pulseStart();
      base = nStrobes;
      sendWord(vecs[i].word);
      check($sformatf("v%0d_strobe", i), outWrInstruction,
            32'(vecs[i].expStrobe));
      if (vecs[i].expStrobe) begin
        check($sformatf("v%0d_data", i), outInstruction, vecs[i].word);
        check($sformatf("v%0d_addr", i), outWrAddress, vecs[i].expAddr);
      end
      @(negedge clk);
      check($sformatf("v%0d_count", i), nStrobes - base,
            32'(vecs[i].expStrobe));
      check($sformatf("v%0d_done", i), outLoadDone, 32'(vecs[i].expDone));
      check($sformatf("v%0d_ovf", i), outOverflow, 32'(vecs[i].expOvf));
      check($sformatf("v%0d_stop", i), outStopPC, 32'(vecs[i].expStop));
`ifndef LOADER_CHECKSUM_EN
      check($sformatf("v%0d_chk", i), outChecksumErr, 32'h0);
`endif
    end

    // Restart after two bytes discards the partial word
    pulseStart();
    sendByte(8'hDE);
    sendByte(8'hAD);
    pulseStart();
    base = nStrobes;
    sendWord(32'h00000007);
    check("restart_data", outInstruction, 32'h00000007);
    check("restart_addr", outWrAddress, 32'h0);
    @(negedge clk);
    check("restart_count", nStrobes - base, 1);

    // Start and byte together: byte is dropped
    base = nStrobes;
    inStart = 1'b1;
    sendByte(8'hAA);
    inStart = 1'b0;
    sendWord(32'h11223344);
    check("collide_strobe", outWrInstruction, 32'h1);
    check("collide_data", outInstruction, 32'h11223344);
    check("collide_addr", outWrAddress, 32'h0);
    @(negedge clk);
    check("collide_count", nStrobes - base, 1);

    // Byte arriving during WRITE starts the next word
    pulseStart();
    base = nStrobes;
    sendWord(32'h01020304);
    check("b2b_first", outInstruction, 32'h01020304);
    sendWord(32'h05060708);
    check("b2b_strobe", outWrInstruction, 32'h1);
    check("b2b_data", outInstruction, 32'h05060708);
    check("b2b_addr", outWrAddress, 32'h1);
    @(negedge clk);
    check("b2b_count", nStrobes - base, 2);

    // Reset on the edge that samples the fourth byte
    pulseStart();
    base = nStrobes;
    sendByte(8'h10);
    sendByte(8'h20);
    sendByte(8'h30);
    rst = 1'b1;
    sendByte(8'h40);
    rst = 1'b0;
    @(negedge clk);
    check("rst4_count", nStrobes - base, 0);
    check("rst4_outs", {outWrInstruction, outStopPC, outLoadDone,
                        outOverflow, outChecksumErr}, 32'h0);
    check("rst4_instr", outInstruction, 32'h0);
    check("rst4_addr", outWrAddress, 32'h0);

    // Reset raised during WRITE kills the strobe
    pulseStart();
    base = nStrobes;
    sendWord(32'hCAFEF00D);
    rst = 1'b1;
    #1;
    check("rstw_strobe", outWrInstruction, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_count", nStrobes - base, 0);
    check("rstw_idle", {outStopPC, outLoadDone}, 32'h0);

`ifdef LOADER_CHECKSUM_EN
    pulseStart();
    sendWord(32'hFFFFFFFF);
    @(negedge clk);
    check("cs0_stop", outStopPC, 32'h1);
    sendByte(8'h00);
    check("cs0_done", outLoadDone, 32'h1);
    check("cs0_err", outChecksumErr, 32'h0);
    pulseStart();
    sendWord(32'hFFFFFFFF);
    @(negedge clk);
    sendByte(8'h01);
    check("cs1_done", outLoadDone, 32'h1);
    check("cs1_err", outChecksumErr, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
